pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch sequencer owning the program counter
//
// Purpose:
//   Sequences IDLE -> FETCH -> ISSUE -> UPDATE -> (FETCH | HALT) for the
//   memory-to-memory vector processor. The PC is advanced through the
//   external combinational PC adder (A = PC, B = increment or branch offset,
//   C written back to PC during UPDATE).
//
// Optional build macro:
//   FETCH_TIMEOUT_EN - enables the fetch watchdog; after TIMEOUT_CYCLES
//                      cycles in FETCH without FETCH_ACK, FAULT is set
//                      (sticky) and the sequencer parks in HALT.
//
// Ports:
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   START           leave IDLE/HALT and begin fetching
//   HALT_REQ        stop at the next instruction boundary (sampled in UPDATE)
//   FETCH_REQ/ADDR  instruction read request and address (= PC)
//   FETCH_ACK       memory returns INSTR_IN this cycle
//   INSTR_IN        fetched instruction
//   INSTR_OUT/VALID registered instruction to the control unit
//   EXEC_DONE       control unit finished the current instruction
//   BRANCH_TAKEN    branch decision, qualified by EXEC_DONE
//   BRANCH_OFFSET   two's-complement offset, qualified by EXEC_DONE
//   ADDER_A/B/C     PC adder operands and sum
//   PC              current program counter
//   HALTED          high in HALT
//   FAULT           fetch timeout flag

module pc_sequencer #(
  parameter int                 WIDTH          = 16,
  parameter logic [WIDTH-1:0]   RESET_PC       = 16'h0000,
  parameter logic [WIDTH-1:0]   PC_INC         = 16'h0002,
  parameter int                 TIMEOUT_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             HALT_REQ,
  output logic             FETCH_REQ,
  output logic [WIDTH-1:0] FETCH_ADDR,
  input  logic             FETCH_ACK,
  input  logic [WIDTH-1:0] INSTR_IN,
  output logic [WIDTH-1:0] INSTR_OUT,
  output logic             INSTR_VALID,
  input  logic             EXEC_DONE,
  input  logic             BRANCH_TAKEN,
  input  logic [WIDTH-1:0] BRANCH_OFFSET,
  output logic [WIDTH-1:0] ADDER_A,
  output logic [WIDTH-1:0] ADDER_B,
  input  logic [WIDTH-1:0] ADDER_C,
  output logic [WIDTH-1:0] PC,
  output logic             HALTED,
  output logic             FAULT
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]       state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] instr_q;
  logic             br_taken;
  logic [WIDTH-1:0] br_off;
  logic             fault_q;
  logic             fetch_timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int              CW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Counts FETCH cycles without an ACK; any exit from FETCH or an ACK clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (state == ST_FETCH && !FETCH_ACK) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Fires in the last permitted FETCH cycle so the exit happens after exactly
  // TIMEOUT_CYCLES cycles of waiting.
  assign fetch_timeout = (state == ST_FETCH) && !FETCH_ACK && (cnt == CNT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fault_q <= 1'b0;
    end else if (fetch_timeout) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign fetch_timeout = 1'b0;
  assign fault_q       = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      instr_q  <= '0;
      br_taken <= 1'b0;
      br_off   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (FETCH_ACK) begin
            instr_q <= INSTR_IN;
            state   <= ST_ISSUE;
          end else if (fetch_timeout) begin
            state <= ST_HALT;
          end
        end
        ST_ISSUE: begin
          if (EXEC_DONE) begin
            br_taken <= BRANCH_TAKEN;
            br_off   <= BRANCH_OFFSET;
            state    <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          // Adder wraps modulo 2^WIDTH, so backward branches need no special case.
          pc    <= ADDER_C;
          state <= HALT_REQ ? ST_HALT : ST_FETCH;
        end
        ST_HALT: begin
          // A faulted sequencer stays parked until reset.
          if (START && !fault_q) state <= ST_FETCH;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign FETCH_REQ   = (state == ST_FETCH);
  assign FETCH_ADDR  = pc;
  assign INSTR_OUT   = instr_q;
  assign INSTR_VALID = (state == ST_ISSUE);
  assign PC          = pc;
  assign HALTED      = (state == ST_HALT);
  assign FAULT       = fault_q;

  // The adder always sees PC + increment except while the branch result is
  // being committed in UPDATE.
  assign ADDER_A = pc;
  assign ADDER_B = (state == ST_UPDATE && br_taken) ? br_off : PC_INC;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        HALT_REQ = 1'b0;
  logic        FETCH_ACK = 1'b0;
  logic        EXEC_DONE = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [15:0] INSTR_IN = 16'h0000;
  logic [15:0] BRANCH_OFFSET = 16'h0000;
  logic        FETCH_REQ, INSTR_VALID, HALTED, FAULT;
  logic [15:0] FETCH_ADDR, INSTR_OUT, ADDER_A, ADDER_B, ADDER_C, PC;

  // Model of the external combinational PC adder.
  assign ADDER_C = ADDER_A + ADDER_B;

  pc_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .HALT_REQ(HALT_REQ),
    .FETCH_REQ(FETCH_REQ), .FETCH_ADDR(FETCH_ADDR), .FETCH_ACK(FETCH_ACK),
    .INSTR_IN(INSTR_IN), .INSTR_OUT(INSTR_OUT), .INSTR_VALID(INSTR_VALID),
    .EXEC_DONE(EXEC_DONE), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_OFFSET(BRANCH_OFFSET), .ADDER_A(ADDER_A), .ADDER_B(ADDER_B),
    .ADDER_C(ADDER_C), .PC(PC), .HALTED(HALTED), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_instr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: each new fetch request and each newly issued instruction is
  // matched against the next expected entry.
  logic prev_req = 1'b0;
  logic prev_val = 1'b0;
  always @(negedge CLK) begin
    if (FETCH_REQ && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        $display("FAIL fetch_unexpected: got addr %h expected none", FETCH_ADDR);
      end else begin
        check("fetch_addr", FETCH_ADDR, exp_addr_q.pop_front());
      end
    end
    if (INSTR_VALID && !prev_val) begin
      if (exp_instr_q.size() == 0) begin
        n_checks++;
        $display("FAIL issue_unexpected: got instr %h expected none", INSTR_OUT);
      end else begin
        check("issue_instr", INSTR_OUT, exp_instr_q.pop_front());
      end
    end
    prev_req <= FETCH_REQ;
    prev_val <= INSTR_VALID;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, PC, 16'h0000);
    check({tag, "_instr_out"}, INSTR_OUT, 16'h0000);
    check({tag, "_outs"}, {FETCH_REQ, INSTR_VALID, HALTED, FAULT}, 4'b0000);
    check({tag, "_adder_b"}, ADDER_B, 16'h0002);
  endtask

  task automatic start_pulse();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // One full instruction: FETCH for ack_n cycles, ISSUE for exec_n cycles,
  // then UPDATE. Expected PC is computed here from addr/taken/off.
  task automatic run_instr(input logic [15:0] addr, input logic [15:0] instr,
                           input int ack_n, input int exec_n,
                           input logic taken, input logic [15:0] off,
                           input logic halt);
    logic [15:0] exp_b;
    logic [15:0] exp_pc;
    int guard;
    exp_b  = taken ? off : 16'h0002;
    exp_pc = addr + exp_b;
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(instr);
    guard = 0;
    while (!FETCH_REQ && guard < 50) begin
      tick();
      guard++;
    end
    if (!FETCH_REQ) begin
      n_checks++;
      $display("FAIL fetch_wait: got no FETCH_REQ expected one within 50 cycles");
      return;
    end
    for (int i = 1; i <= ack_n; i++) begin
      check("fetch_req_held", FETCH_REQ, 1);
      check("pc_in_fetch", PC, addr);
      FETCH_ACK = (i == ack_n);
      INSTR_IN  = (i == ack_n) ? instr : 16'hBAD0 + i[15:0];
      tick();
    end
    FETCH_ACK = 1'b0;
    check("fetch_req_drop", FETCH_REQ, 0);
    for (int j = 1; j <= exec_n; j++) begin
      check("instr_valid_held", INSTR_VALID, 1);
      check("instr_out_stable", INSTR_OUT, instr);
      check("pc_in_issue", PC, addr);
      if (halt && j == (exec_n + 1) / 2) HALT_REQ = 1'b1;
      EXEC_DONE     = (j == exec_n);
      BRANCH_TAKEN  = (j == exec_n) ? taken : 1'b1;
      BRANCH_OFFSET = (j == exec_n) ? off : 16'h1234;
      FETCH_ACK     = (j != exec_n);
      INSTR_IN      = 16'hDEAD;
      tick();
    end
    EXEC_DONE = 1'b0;
    BRANCH_TAKEN = 1'b0;
    BRANCH_OFFSET = 16'h0000;
    FETCH_ACK = 1'b0;
    check("update_valid_low", INSTR_VALID, 0);
    check("update_adder_a", ADDER_A, addr);
    check("update_adder_b", ADDER_B, exp_b);
    check("update_pc_hold", PC, addr);
    tick();
    HALT_REQ = 1'b0;
    check("pc_after_update", PC, exp_pc);
    check("halted_after_update", HALTED, halt);
    check("fetch_after_update", FETCH_REQ, !halt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    repeat (2) tick();
    RST_N = 1'b1;
    tick();
    check_reset_state("reset");
    tick();
    tick();
    check("idle_holds", FETCH_REQ, 0);

    // Three sequential instructions; HALT_REQ raised mid-ISSUE on the third.
    start_pulse();
    run_instr(16'h0000, 16'h1001, 1, 1, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h0002, 16'h1002, 1, 1, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h0004, 16'h1003, 1, 3, 1'b0, 16'h0000, 1'b1);
    repeat (3) tick();
    check("halt_pc_frozen", PC, 16'h0006);
    check("halt_state", {HALTED, FETCH_REQ}, 2'b10);

    // START and HALT_REQ together in HALT: one slow instruction then halt again.
    HALT_REQ = 1'b1;
    start_pulse();
    check("start_wins", FETCH_REQ, 1);
    run_instr(16'h0006, 16'h2006, 5, 20, 1'b0, 16'h0000, 1'b1);

    start_pulse();
    run_instr(16'h0008, 16'h2008, 1, 1, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h000A, 16'h200A, 1, 1, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h000C, 16'h200C, 1, 1, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h000E, 16'h200E, 1, 1, 1'b0, 16'h0000, 1'b0);
    // Backward branch 0010 + FFF8 -> 0008, then to FFFE and wrap to 0000.
    run_instr(16'h0010, 16'h3010, 1, 1, 1'b1, 16'hFFF8, 1'b0);
    run_instr(16'h0008, 16'h3008, 2, 1, 1'b1, 16'hFFF6, 1'b0);
    run_instr(16'hFFFE, 16'h3FFE, 1, 2, 1'b0, 16'h0000, 1'b0);
    run_instr(16'h0000, 16'h4000, 1, 1, 1'b0, 16'h0000, 1'b0);

    // Asynchronous reset in the middle of ISSUE at PC=0002.
    exp_addr_q.push_back(16'h0002);
    exp_instr_q.push_back(16'h4002);
    FETCH_ACK = 1'b1;
    INSTR_IN  = 16'h4002;
    tick();
    FETCH_ACK = 1'b0;
    check("pre_reset_issue", {INSTR_VALID, INSTR_OUT}, {1'b1, 16'h4002});
    tick();
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_state("async_reset");
    tick();
    RST_N = 1'b1;
    tick();
    check_reset_state("after_reset");

    start_pulse();
    run_instr(16'h0000, 16'h5000, 1, 1, 1'b0, 16'h0000, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    start_pulse();
    exp_addr_q.push_back(16'h0002);
    for (int k = 0; k < 16; k++) begin
      check("timeout_fetch_req", FETCH_REQ, 1);
      tick();
    end
    check("timeout_flags", {HALTED, FAULT, FETCH_REQ}, 3'b110);
    check("timeout_pc", PC, 16'h0002);
    START = 1'b1;
    tick();
    tick();
    START = 1'b0;
    check("fault_start_ignored", {HALTED, FETCH_REQ}, 2'b10);
`endif

    tick();
    check("scoreboard_drained", exp_addr_q.size() + exp_instr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
